// File: rtl/mod_div_pkg.sv
// Shared types and elaboration helpers for the DIV/MOD unit.
// MOD_DIV_SIGNED_EN adds the SIGN fix-up state to the latency figure.
package mod_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_SIGN = 2'd3
  } state_t;

  // Accept edge to the edge that first samples out_valid, for a non-zero divisor.
  function automatic int cycles(input int width, input int steps);
`ifdef MOD_DIV_SIGNED_EN
    return width / steps + 2;
`else
    return width / steps + 1;
`endif
  endfunction

  function automatic bit steps_legal(input int width, input int steps);
    return (width >= 4) && ((steps == 1) || (steps == 2) || (steps == 4)) && ((width % steps) == 0);
  endfunction

endpackage

// File: rtl/mod_div_step.sv
// One combinational restoring shift-subtract step of the divider.
module mod_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] trial;
  logic             unused_trial_bit;

  assign partial = {rem_in, bit_in};
  assign trial   = {1'b0, partial} - {2'b00, divisor};
  assign q_bit   = ~trial[WIDTH+1];
  // Either result is below the divisor, so it always fits in WIDTH bits.
  assign rem_out = q_bit ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
  assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/mod_div_unit.sv
// Multi-cycle restoring divider (quotient + remainder) with valid/ready on both sides.
// Build option MOD_DIV_SIGNED_EN: two's complement operands, C-style results, extra SIGN cycle.
module mod_div_unit
  import mod_div_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             out_lt
);

  localparam int  N_CYC     = WIDTH / STEPS_PER_CYCLE;
  localparam int  CW        = $clog2(N_CYC + 1);
  localparam bit  CFG_LEGAL = steps_legal(WIDTH, STEPS_PER_CYCLE);
  localparam logic [CW-1:0] LAST = CW'(N_CYC - 1);

  if (!CFG_LEGAL) begin : g_cfg_check
    $error("mod_div_unit: STEPS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH (>=4)");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic             lt_q;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem_fin;
  logic [WIDTH-1:0] quo_fin;
  logic             accept;

`ifdef MOD_DIV_SIGNED_EN
  logic q_neg;
  logic r_neg;

  assign a_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign b_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_ready && in_valid && !abort;

  // Step chain: the quotient register doubles as the dividend shifter, MSB first.
  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] q_out;
    logic             q_bit;

    if (i == 0) begin : g_first
      assign r_in = rem_q;
      assign q_in = quo_q;
    end else begin : g_next
      assign r_in = g_step[i-1].r_out;
      assign q_in = g_step[i-1].q_out;
    end

    mod_div_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .rem_in  (r_in),
      .bit_in  (q_in[WIDTH-1]),
      .divisor (div_q),
      .rem_out (r_out),
      .q_bit   (q_bit)
    );

    assign q_out = {q_in[WIDTH-2:0], q_bit};
  end

  assign rem_fin = g_step[STEPS_PER_CYCLE-1].r_out;
  assign quo_fin = g_step[STEPS_PER_CYCLE-1].q_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      lt_q        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_lt      <= 1'b0;
`ifdef MOD_DIV_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            div_q <= b_mag;
            rem_q <= '0;
            quo_q <= a_mag;
            cnt   <= '0;
            lt_q  <= (a_mag < b_mag);
`ifdef MOD_DIV_SIGNED_EN
            q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg <= dividend[WIDTH-1];
`endif
            // Divide-by-zero skips the datapath entirely; outputs land with the DONE transition.
            if (divisor == '0) begin
              state       <= ST_DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_lt      <= 1'b0;
            end else begin
              state <= ST_BUSY;
            end
          end
        end

        ST_BUSY: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            rem_q <= rem_fin;
            quo_q <= quo_fin;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
`ifdef MOD_DIV_SIGNED_EN
              state <= ST_SIGN;
`else
              state       <= ST_DONE;
              quotient    <= quo_fin;
              remainder   <= rem_fin;
              div_by_zero <= 1'b0;
              out_lt      <= lt_q;
`endif
            end
          end
        end

`ifdef MOD_DIV_SIGNED_EN
        ST_SIGN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            state       <= ST_DONE;
            quotient    <= q_neg ? (~quo_q + 1'b1) : quo_q;
            remainder   <= r_neg ? (~rem_q + 1'b1) : rem_q;
            div_by_zero <= 1'b0;
            out_lt      <= lt_q;
          end
        end
`endif

        ST_DONE: begin
          if (abort || out_ready) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_div_unit.sv
// Directed and randomized bench for mod_div_unit (32-bit/1-step and 16-bit/4-step instances).
module tb_mod_div_unit;

`ifdef MOD_DIV_SIGNED_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT32 = 33 + EXTRA;
  localparam int LAT16 = 5 + EXTRA;

  logic clk;
  logic reset_n;

  logic        v32, ir32, ab32, ov32, or32, z32, lt32;
  logic [31:0] a32, b32, q32, r32;
  logic        v16, ir16, ab16, ov16, or16, z16, lt16;
  logic [15:0] a16, b16, q16, r16;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  mod_div_unit #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(v32), .in_ready(ir32),
    .dividend(a32), .divisor(b32), .abort(ab32), .out_valid(ov32), .out_ready(or32),
    .quotient(q32), .remainder(r32), .div_by_zero(z32), .out_lt(lt32)
  );

  mod_div_unit #(.WIDTH(16), .STEPS_PER_CYCLE(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(v16), .in_ready(ir16),
    .dividend(a16), .divisor(b16), .abort(ab16), .out_valid(ov16), .out_ready(or16),
    .quotient(q16), .remainder(r16), .div_by_zero(z16), .out_lt(lt16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk); a32 = a; b32 = b; v32 = 1'b1;
    @(negedge clk); v32 = 1'b0; lat = 1;
    while (!ov32 && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic rel32();
    @(negedge clk); or32 = 1'b1;
    @(negedge clk); or32 = 1'b0;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clk); a16 = a; b16 = b; v16 = 1'b1;
    @(negedge clk); v16 = 1'b0; lat = 1;
    while (!ov16 && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic rel16();
    @(negedge clk); or16 = 1'b1;
    @(negedge clk); or16 = 1'b0;
  endtask

  // Reference: plain integer division on the operand values (C semantics when signed).
  task automatic model16(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] eq, output logic [15:0] er,
                         output logic ez, output logic elt, output int elat);
    int sa, sb, ma, mb;
    if (b == 16'd0) begin
      eq = 16'hFFFF; er = a; ez = 1'b1; elt = 1'b0; elat = 1;
    end else begin
`ifdef MOD_DIV_SIGNED_EN
      sa = int'($signed(a)); sb = int'($signed(b));
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      eq = 16'(sa / sb); er = 16'(sa % sb); elt = (ma < mb);
`else
      sa = int'(a); sb = int'(b);
      eq = 16'(sa / sb); er = 16'(sa % sb); elt = (sa < sb);
      ma = 0; mb = 0;
`endif
      ez = 1'b0; elat = LAT16;
    end
  endtask

  initial begin
    int lat;
    bit seen;
    logic [15:0] ra, rb, eq, er;
    logic ez, elt;
    int elat;

    reset_n = 1'b0;
    v32 = 0; ab32 = 0; or32 = 0; a32 = '0; b32 = '0;
    v16 = 0; ab16 = 0; or16 = 0; a16 = '0; b16 = '0;
    #22;
    check("rst_in_ready", ir32, 1);
    check("rst_out_valid", ov32, 0);
    check("rst_quotient", q32, 0);
    check("rst_remainder", r32, 0);
    check("rst_dbz_lt", {z32, lt32}, 0);
    @(negedge clk); reset_n = 1'b1;

    // 100 / 7
    op32(32'd100, 32'd7, lat);
    check("t1_latency", lat, LAT32);
    check("t1_quotient", q32, 14);
    check("t1_remainder", r32, 2);
    check("t1_lt_dbz", {lt32, z32}, 0);
    check("t1_in_ready_done", ir32, 0);
    rel32();
    check("t1_idle", {ir32, ov32}, 2'b10);
    check("t1_hold_idle", q32, 14);

    // 5 / 9 held unconsumed for ten cycles
    op32(32'd5, 32'd9, lat);
    check("t2_latency", lat, LAT32);
    check("t2_lt", lt32, 1);
    repeat (10) @(negedge clk);
    check("t2_hold_valid", ov32, 1);
    check("t2_hold_quotient", q32, 0);
    check("t2_hold_remainder", r32, 5);
    // out_ready with in_valid in DONE: leaves to IDLE without accepting
    @(negedge clk); a32 = 77; b32 = 1; v32 = 1; or32 = 1;
    @(negedge clk); v32 = 0; or32 = 0;
    check("t2_no_accept_in_done", {ir32, ov32}, 2'b10);

    // divide by zero
    op32(32'd123, 32'd0, lat);
    check("t3_latency", lat, 1);
    check("t3_quotient", q32, 32'hFFFF_FFFF);
    check("t3_remainder", r32, 123);
    check("t3_dbz_lt", {z32, lt32}, 2'b10);
    rel32();

    // abort together with in_valid in IDLE
    @(negedge clk); a32 = 50; b32 = 5; v32 = 1; ab32 = 1;
    @(negedge clk); v32 = 0; ab32 = 0;
    check("abort_idle_no_accept", ir32, 1);

    // abort during BUSY
    @(negedge clk); a32 = 1000; b32 = 3; v32 = 1;
    @(negedge clk); v32 = 0;
    repeat (9) @(negedge clk);
    ab32 = 1;
    @(negedge clk); ab32 = 0;
    check("t4_abort_idle", {ir32, ov32}, 2'b10);
    seen = 0;
    repeat (40) begin @(negedge clk); if (ov32) seen = 1; end
    check("t4_no_valid", seen, 0);
    check("t4_retain", {q32, r32}, {32'hFFFF_FFFF, 32'd123});
    op32(32'd40, 32'd6, lat);
    check("t4_latency", lat, LAT32);
    check("t4_result", {q32, r32}, {32'd6, 32'd4});
    rel32();

    // asynchronous reset mid-BUSY
    @(negedge clk); a32 = 200; b32 = 9; v32 = 1;
    @(negedge clk); v32 = 0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_outputs", {q32, r32, z32, lt32, ov32}, 0);
    check("t5_in_ready_in_reset", ir32, 1);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("t5_in_ready_after", {ir32, ov32}, 2'b10);

`ifdef MOD_DIV_SIGNED_EN
    op16(16'hFFF9, 16'd2, lat);
    check("signed_m7_div_2", {q16, r16}, {16'hFFFD, 16'hFFFF});
    rel16();
`endif

    // randomized 16-bit, 4 steps per cycle
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 16'($urandom_range(0, 20));
      case ($urandom_range(0, 9))
        0:       rb = 16'd0;
        1, 2, 3: rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      model16(ra, rb, eq, er, ez, elt, elat);
      op16(ra, rb, lat);
      check("rnd_latency", lat, elat);
      check("rnd_quotient", q16, eq);
      check("rnd_remainder", r16, er);
      check("rnd_flags", {z16, lt16}, {ez, elt});
      rel16();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
